// File: rtl/pipeline_skid_register_if.sv
// pipeline_skid_register_if: upstream/downstream handshake bundle for one skid-buffered pipeline stage.
interface pipeline_skid_register_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register: two-entry skid stage with fully registered in_ready/out_valid and flush-to-bubble.
module pipeline_skid_register #(
    parameter int              DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input logic                    clk,
    input logic                    rst,
    pipeline_skid_register_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_xfer) begin
                main_d  = bus.in_data;
                state_d = BUSY;
            end
            BUSY: if (in_xfer && out_xfer) begin
                main_d = bus.in_data;
            end else if (in_xfer) begin
                skid_d  = bus.in_data;
                state_d = FULL;
            end else if (out_xfer) begin
                main_d  = NOP_VALUE;
                state_d = EMPTY;
            end
            FULL: if (out_xfer) begin
                main_d  = skid_q;
                state_d = BUSY;
            end
            default: begin
                main_d  = NOP_VALUE;
                state_d = EMPTY;
            end
        endcase
        // flush overrides every transfer; any in-transfer this cycle is dropped
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end
        in_ready_d  = state_d != FULL;
        out_valid_d = state_d != EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;
endmodule
